tri_pwm_dac: RTL and testbench

Output stage that sits directly downstream of the triangle wave generator. It takes the generator's 4-bit sample (D3..D0) and brings it safely into the CLK domain. It scales the sample by a 4-bit volume loaded over the shared DIN nibble bus, then drives a single-bit PWM audio pin whose duty cycle tracks the scaled level.

---
 rtl/tri_pwm_dac_pkg.sv | 11 +
 rtl/tri_pwm_dac_if.sv | 23 ++
 rtl/tri_sample_sync.sv | 40 ++++
 rtl/tri_pwm_dac.sv | 91 +++++++++
 tb/tb_tri_pwm_dac.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_pwm_dac_pkg.sv
// Shared widths and constants for the triangle-channel PWM DAC slice.
package tri_pwm_dac_pkg;

  localparam int unsigned SAMPLE_W   = 4;
  localparam int unsigned VOL_W      = 4;
  localparam int unsigned DIN_W      = 4;
  // Level width is the full product width, so 15*15 never overflows.
  localparam int unsigned PWM_W      = SAMPLE_W + VOL_W;
  localparam int unsigned PWM_PERIOD = 1 << PWM_W;

endpackage

// File: rtl/tri_pwm_dac_if.sv
// Sample/register/PWM signal bundle between the generator side and the DAC.
interface tri_pwm_dac_if;
  import tri_pwm_dac_pkg::*;

  logic [SAMPLE_W-1:0] SAMPLE;
  logic [DIN_W-1:0]    DIN;
  logic                VSEL;
  logic                ENABLE;
  logic                PWM_OUT;
  logic                PERIOD_STB;
  logic [PWM_W-1:0]    LEVEL;

  modport master (
    output SAMPLE, DIN, VSEL, ENABLE,
    input  PWM_OUT, PERIOD_STB, LEVEL
  );

  modport slave (
    input  SAMPLE, DIN, VSEL, ENABLE,
    output PWM_OUT, PERIOD_STB, LEVEL
  );

endinterface

// File: rtl/tri_sample_sync.sv
// Brings an asynchronous, possibly glitching waveform code into the clk domain
// and only accepts a code once it has been seen on two consecutive cycles.
module tri_sample_sync
  import tri_pwm_dac_pkg::*;
#(
  parameter int unsigned W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sampleIn,
  output logic [W-1:0] sampleQ
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s3;

  // Three-stage shift; s3 only serves as the stability reference for s2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= sampleIn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Capture only codes that held for two synchronized cycles (rejects 1-cycle glitches).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sampleQ <= '0;
    end else if (s2 == s3) begin
      sampleQ <= s2;
    end
  end

endmodule

// File: rtl/tri_pwm_dac.sv
// Volume-scaled PWM output stage for the triangle channel.
module tri_pwm_dac
  import tri_pwm_dac_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  tri_pwm_dac_if.slave  bus
);

  logic [SAMPLE_W-1:0] sampleQ;
  logic [VOL_W-1:0]    volQ;
  logic [PWM_W-1:0]    prodQ;
  logic [PWM_W-1:0]    levelQ;
  logic [PWM_W-1:0]    cnt;
  logic [PWM_W-1:0]    levelNext;
  logic                periodStart;
  logic                pwmOut;
  logic                periodStb;

  tri_sample_sync #(
    .W (SAMPLE_W)
  ) uSync (
    .clk      (CLK),
    .rst      (RST),
    .sampleIn (bus.SAMPLE),
    .sampleQ  (sampleQ)
  );

  // Volume register written from the shared nibble bus.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      volQ <= '0;
    end else if (bus.VSEL) begin
      volQ <= bus.DIN[VOL_W-1:0];
    end
  end

  // Registered unsigned scale; uses the volume value from before any same-cycle load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prodQ <= '0;
    end else begin
      prodQ <= PWM_W'(sampleQ) * PWM_W'(volQ);
    end
  end

  // Period boundary: the level loads here, and the first output bit already uses it.
  always_comb begin
    periodStart = bus.ENABLE && (cnt == '0);
    levelNext   = levelQ;
    if (periodStart) begin
      levelNext = prodQ;
    end
  end

  // Free-running period counter, parked at zero while disabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (!bus.ENABLE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PWM_W'(1);
    end
  end

  // Duty level only changes at a period boundary; holds while disabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      levelQ <= '0;
    end else begin
      levelQ <= levelNext;
    end
  end

  // Registered comparator output and period strobe, aligned with each other.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwmOut    <= 1'b0;
      periodStb <= 1'b0;
    end else begin
      pwmOut    <= bus.ENABLE && (cnt < levelNext);
      periodStb <= periodStart;
    end
  end

  assign bus.PWM_OUT    = pwmOut;
  assign bus.PERIOD_STB = periodStb;
  assign bus.LEVEL      = levelQ;

endmodule

// File: tb/tb_tri_pwm_dac.sv
// Directed self-checking bench for tri_pwm_dac.
module tb_tri_pwm_dac;
  import tri_pwm_dac_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  tri_pwm_dac_if bus ();

  tri_pwm_dac dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ENABLE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.SAMPLE = SAMPLE_W'($urandom_range(15));
      bus.DIN    = DIN_W'($urandom_range(15));
      bus.VSEL   = 1'($urandom_range(1));
      step(1);
      total++;
      if (bus.PWM_OUT !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%0b exp=0", bus.PWM_OUT); end
      total++;
      if (bus.PERIOD_STB !== 1'b0) begin bad++; $display("FAIL reset_stb got=%0b exp=0", bus.PERIOD_STB); end
      total++;
      if (bus.LEVEL !== 8'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", bus.LEVEL); end
    end
    bus.VSEL   = 1'b0;
    bus.ENABLE = 1'b0;
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_full_scale();
    int highs;
    int stbs;
    bus.SAMPLE = 4'hF;
    bus.DIN    = 4'hF;
    bus.VSEL   = 1'b1;
    step(1);
    bus.VSEL   = 1'b0;
    step(8);
    total++;
    if (bus.LEVEL !== 8'd0) begin bad++; $display("FAIL fs_level_hold got=%0d exp=0", bus.LEVEL); end
    bus.ENABLE = 1'b1;
    step(1);
    total++;
    if (bus.LEVEL !== 8'd225) begin bad++; $display("FAIL fs_level got=%0d exp=225", bus.LEVEL); end
    highs = int'(bus.PWM_OUT);
    stbs  = int'(bus.PERIOD_STB);
    for (int i = 1; i < PWM_PERIOD; i++) begin
      step(1);
      highs += int'(bus.PWM_OUT);
      stbs  += int'(bus.PERIOD_STB);
    end
    total++;
    if (highs != 225) begin bad++; $display("FAIL fs_highs got=%0d exp=225", highs); end
    total++;
    if (stbs != 1) begin bad++; $display("FAIL fs_stbs got=%0d exp=1", stbs); end
    step(1);
    total++;
    if (bus.PERIOD_STB !== 1'b1) begin bad++; $display("FAIL fs_next_stb got=%0b exp=1", bus.PERIOD_STB); end
  endtask

  task automatic test_reset_mid();
    step(60);
    total++;
    if (bus.PWM_OUT !== 1'b1) begin bad++; $display("FAIL mid_pre_pwm got=%0b exp=1", bus.PWM_OUT); end
    rst = 1'b1;
    #2;
    total++;
    if (bus.PWM_OUT !== 1'b0) begin bad++; $display("FAIL mid_rst_pwm got=%0b exp=0", bus.PWM_OUT); end
    total++;
    if (bus.LEVEL !== 8'd0) begin bad++; $display("FAIL mid_rst_level got=%0d exp=0", bus.LEVEL); end
    step(2);
    rst = 1'b0;
    step(1);
    total++;
    if (bus.PERIOD_STB !== 1'b1) begin bad++; $display("FAIL post_rst_stb got=%0b exp=1", bus.PERIOD_STB); end
    bus.ENABLE = 1'b0;
  endtask

  task automatic test_mute();
    int highs;
    bus.SAMPLE = 4'hA;
    step(8);
    bus.ENABLE = 1'b1;
    step(1);
    total++;
    if (bus.PERIOD_STB !== 1'b1 || bus.LEVEL !== 8'd0) begin
      bad++; $display("FAIL mute_start got stb=%0b level=%0d exp stb=1 level=0", bus.PERIOD_STB, bus.LEVEL);
    end
    highs = int'(bus.PWM_OUT);
    for (int i = 1; i < PWM_PERIOD; i++) begin
      bus.DIN  = 4'h3;
      bus.VSEL = (i == 100);
      step(1);
      highs += int'(bus.PWM_OUT);
    end
    bus.VSEL = 1'b0;
    total++;
    if (highs != 0) begin bad++; $display("FAIL mute_highs got=%0d exp=0", highs); end
    total++;
    if (bus.LEVEL !== 8'd0) begin bad++; $display("FAIL mute_level_hold got=%0d exp=0", bus.LEVEL); end
    step(1);
    total++;
    if (bus.LEVEL !== 8'd30) begin bad++; $display("FAIL vol3_level got=%0d exp=30", bus.LEVEL); end
    highs = int'(bus.PWM_OUT);
    for (int i = 1; i < PWM_PERIOD; i++) begin
      step(1);
      highs += int'(bus.PWM_OUT);
    end
    total++;
    if (highs != 30) begin bad++; $display("FAIL vol3_highs got=%0d exp=30", highs); end
    bus.ENABLE = 1'b0;
  endtask

  task automatic test_glitch();
    int wrong;
    bus.SAMPLE = 4'h5;
    step(5);
    total++;
    if (dut.sampleQ !== 4'h5) begin bad++; $display("FAIL glitch_base got=%0h exp=5", dut.sampleQ); end
    bus.SAMPLE = 4'hF;
    step(1);
    bus.SAMPLE = 4'h5;
    wrong = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (dut.sampleQ !== 4'h5) wrong++;
    end
    total++;
    if (wrong != 0) begin bad++; $display("FAIL glitch_reject bad_cycles=%0d exp=0", wrong); end
    bus.SAMPLE = 4'h6;
    step(3);
    bus.SAMPLE = 4'h5;
    total++;
    if (dut.sampleQ !== 4'h5) begin bad++; $display("FAIL hold6_early got=%0h exp=5", dut.sampleQ); end
    step(1);
    total++;
    if (dut.sampleQ !== 4'h6) begin bad++; $display("FAIL hold6_capture got=%0h exp=6", dut.sampleQ); end
    step(1);
    total++;
    if (dut.prodQ !== 8'd18) begin bad++; $display("FAIL hold6_prod got=%0d exp=18", dut.prodQ); end
  endtask

  task automatic test_vsel_timing();
    bus.SAMPLE = 4'h1;
    bus.DIN    = 4'hF;
    bus.VSEL   = 1'b1;
    step(1);
    bus.VSEL   = 1'b0;
    step(6);
    total++;
    if (dut.prodQ !== 8'd15) begin bad++; $display("FAIL vsel_pre got=%0d exp=15", dut.prodQ); end
    bus.DIN  = 4'h2;
    bus.VSEL = 1'b1;
    step(1);
    bus.VSEL = 1'b0;
    total++;
    if (dut.prodQ !== 8'd15) begin bad++; $display("FAIL vsel_old_vol got=%0d exp=15", dut.prodQ); end
    step(1);
    total++;
    if (dut.prodQ !== 8'd2) begin bad++; $display("FAIL vsel_new_vol got=%0d exp=2", dut.prodQ); end
  endtask

  task automatic test_mid_period();
    int highs;
    bus.DIN    = 4'hF;
    bus.VSEL   = 1'b1;
    bus.SAMPLE = 4'h2;
    step(1);
    bus.VSEL   = 1'b0;
    step(6);
    bus.ENABLE = 1'b1;
    step(1);
    total++;
    if (bus.LEVEL !== 8'd30) begin bad++; $display("FAIL midchg_start got=%0d exp=30", bus.LEVEL); end
    highs = int'(bus.PWM_OUT);
    for (int i = 1; i < PWM_PERIOD; i++) begin
      if (i == 100) bus.SAMPLE = 4'hC;
      step(1);
      highs += int'(bus.PWM_OUT);
    end
    total++;
    if (highs != 30 || bus.LEVEL !== 8'd30) begin
      bad++; $display("FAIL midchg_keep got highs=%0d level=%0d exp 30/30", highs, bus.LEVEL);
    end
    step(1);
    total++;
    if (bus.LEVEL !== 8'd180 || bus.PERIOD_STB !== 1'b1) begin
      bad++; $display("FAIL midchg_next got level=%0d stb=%0b exp 180/1", bus.LEVEL, bus.PERIOD_STB);
    end
  endtask

  task automatic test_enable_gating();
    int act;
    step(49);
    total++;
    if (bus.PWM_OUT !== 1'b1) begin bad++; $display("FAIL gate_pre_pwm got=%0b exp=1", bus.PWM_OUT); end
    bus.ENABLE = 1'b0;
    step(1);
    total++;
    if (bus.PWM_OUT !== 1'b0 || bus.PERIOD_STB !== 1'b0 || bus.LEVEL !== 8'd180) begin
      bad++; $display("FAIL gate_off got pwm=%0b stb=%0b level=%0d exp 0/0/180", bus.PWM_OUT, bus.PERIOD_STB, bus.LEVEL);
    end
    bus.SAMPLE = 4'h1;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      act += int'(bus.PWM_OUT) + int'(bus.PERIOD_STB);
    end
    total++;
    if (act != 0 || bus.LEVEL !== 8'd180) begin
      bad++; $display("FAIL gate_hold got activity=%0d level=%0d exp 0/180", act, bus.LEVEL);
    end
    bus.ENABLE = 1'b1;
    step(1);
    total++;
    if (bus.PERIOD_STB !== 1'b1 || bus.LEVEL !== 8'd15 || bus.PWM_OUT !== 1'b1) begin
      bad++; $display("FAIL gate_reen got stb=%0b level=%0d pwm=%0b exp 1/15/1", bus.PERIOD_STB, bus.LEVEL, bus.PWM_OUT);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.SAMPLE = '0;
    bus.DIN    = '0;
    bus.VSEL   = 1'b0;
    bus.ENABLE = 1'b0;
    test_reset();
    test_full_scale();
    test_reset_mid();
    test_mute();
    test_glitch();
    test_vsel_timing();
    test_mid_period();
    test_enable_gating();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
